// File: rtl/cyc_bus_arbiter_if.sv
// Bundle of requester-side and sequencer-side signals for the cycle arbiter.
// The arbiter takes the slave view; the requester/sequencer side takes master.
interface cyc_bus_arbiter_if;
  logic REFRQ_n;
  logic DMARQ_n;
  logic MREQ_n;
  logic IORQ_n;
  logic LOCK_n;
  logic CYCEND;
  logic GNT_REF;
  logic GNT_DMA;
  logic GNT_MEM;
  logic GNT_IO;
  logic CGNTCACT_n;
  logic CYCSTART;
  logic BUSY;
  logic TMO;
  logic REFLATE;

  modport master (
    output REFRQ_n, DMARQ_n, MREQ_n, IORQ_n, LOCK_n, CYCEND,
    input  GNT_REF, GNT_DMA, GNT_MEM, GNT_IO, CGNTCACT_n,
    input  CYCSTART, BUSY, TMO, REFLATE
  );

  modport slave (
    input  REFRQ_n, DMARQ_n, MREQ_n, IORQ_n, LOCK_n, CYCEND,
    output GNT_REF, GNT_DMA, GNT_MEM, GNT_IO, CGNTCACT_n,
    output CYCSTART, BUSY, TMO, REFLATE
  );
endinterface

// File: rtl/cyc_bus_arbiter.sv
// Cycle resource arbiter: picks one of refresh/DMA/CPU-mem/CPU-IO, launches the
// cycle with CYCSTART, holds the grant until CYCEND or timeout, then recovers.
module cyc_bus_arbiter #(
  parameter int unsigned RECOV_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned REF_LATE    = 16
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             MR_n,
  cyc_bus_arbiter_if.slave bus
);

  localparam int unsigned ACT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned REF_W = $clog2(REF_LATE + 1);

  localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(TIMEOUT_CYC - 1);
  localparam logic [ACT_W-1:0] ACT_ONE  = ACT_W'(1);
  localparam logic [3:0]       REC_LAST = 4'((RECOV_CYC == 0) ? 0 : RECOV_CYC - 1);
  localparam logic [3:0]       REC_ONE  = 4'd1;
  localparam logic [REF_W-1:0] REF_MAX  = REF_W'(REF_LATE);
  localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);

  // one-hot grant bit positions
  localparam int G_REF = 0;
  localparam int G_DMA = 1;
  localparam int G_MEM = 2;
  localparam int G_IO  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RECOV  = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic             pend_q,     pend_d;
  logic [3:0]       win_q,      win_d;
  logic [3:0]       gnt_q,      gnt_d;
  logic             cycstart_q, cycstart_d;
  logic             tmo_q,      tmo_d;
  logic [ACT_W-1:0] act_cnt_q,  act_cnt_d;
  logic [3:0]       rec_cnt_q,  rec_cnt_d;
  logic [REF_W-1:0] refw_q,     refw_d;
  logic             reflate_q,  reflate_d;
  logic             lock_cpu_q, lock_cpu_d;

  logic [3:0] req;
  logic [3:0] win_pick;
  logic       lock_hold;
  logic       launch;
  logic       cyc_done;
  logic       timed_out;

  assign req = {~bus.IORQ_n, ~bus.MREQ_n, ~bus.DMARQ_n, ~bus.REFRQ_n};

  // The lock only favours the CPU when the CPU held the bus last; refresh
  // grants are transparent to that history so a locked sequence survives them.
  assign lock_hold = ~bus.LOCK_n & lock_cpu_q;

  always_comb begin
    win_pick = 4'b0000;
    if (req[G_REF]) begin
      win_pick[G_REF] = 1'b1;
    end else if (lock_hold && (req[G_MEM] || req[G_IO])) begin
      if (req[G_MEM]) win_pick[G_MEM] = 1'b1;
      else            win_pick[G_IO]  = 1'b1;
    end else if (req[G_DMA]) begin
      win_pick[G_DMA] = 1'b1;
    end else if (req[G_MEM]) begin
      win_pick[G_MEM] = 1'b1;
    end else if (req[G_IO]) begin
      win_pick[G_IO] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      win_q      <= 4'b0000;
      gnt_q      <= 4'b0000;
      cycstart_q <= 1'b0;
      tmo_q      <= 1'b0;
      act_cnt_q  <= '0;
      rec_cnt_q  <= 4'd0;
      refw_q     <= '0;
      reflate_q  <= 1'b0;
      lock_cpu_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      cycstart_q <= cycstart_d;
      tmo_q      <= tmo_d;
      act_cnt_q  <= act_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
      refw_q     <= refw_d;
      reflate_q  <= reflate_d;
      lock_cpu_q <= lock_cpu_d;
    end
  end

  // Next-state and counters
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    win_d      = win_q;
    act_cnt_d  = act_cnt_q;
    rec_cnt_d  = rec_cnt_q;
    lock_cpu_d = lock_cpu_q;
    refw_d     = refw_q;
    launch     = 1'b0;
    cyc_done   = 1'b0;
    timed_out  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d   = ST_ACTIVE;
          pend_d    = 1'b0;
          act_cnt_d = '0;
          launch    = 1'b1;
          if (win_q[G_DMA])                    lock_cpu_d = 1'b0;
          else if (win_q[G_MEM] || win_q[G_IO]) lock_cpu_d = 1'b1;
        end else begin
          win_d  = win_pick;
          pend_d = |req;
        end
      end
      ST_ACTIVE: begin
        if (bus.CYCEND)                  cyc_done  = 1'b1;
        else if (act_cnt_q == ACT_LAST)  timed_out = 1'b1;
        else                             act_cnt_d = act_cnt_q + ACT_ONE;
        if (cyc_done || timed_out) begin
          rec_cnt_d = 4'd0;
          state_d   = (RECOV_CYC == 0) ? ST_IDLE : ST_RECOV;
        end
      end
      ST_RECOV: begin
        if (rec_cnt_q == REC_LAST) state_d   = ST_IDLE;
        else                       rec_cnt_d = rec_cnt_q + REC_ONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (gnt_q[G_REF])                          refw_d = '0;
    else if (!bus.REFRQ_n && refw_q != REF_MAX) refw_d = refw_q + REF_ONE;
    reflate_d = reflate_q | (refw_d == REF_MAX);

    // Master clear overrides everything decided above, including end/timeout.
    if (!MR_n) begin
      state_d    = ST_IDLE;
      pend_d     = 1'b0;
      win_d      = 4'b0000;
      act_cnt_d  = '0;
      rec_cnt_d  = 4'd0;
      lock_cpu_d = 1'b0;
      refw_d     = '0;
      reflate_d  = 1'b0;
      launch     = 1'b0;
      cyc_done   = 1'b0;
      timed_out  = 1'b0;
    end
  end

  // Registered outputs
  always_comb begin
    gnt_d      = gnt_q;
    cycstart_d = launch;
    tmo_d      = timed_out;
    if (launch)               gnt_d = win_q;
    if (cyc_done || timed_out) gnt_d = 4'b0000;
    if (!MR_n) begin
      gnt_d      = 4'b0000;
      cycstart_d = 1'b0;
      tmo_d      = 1'b0;
    end
  end

  assign bus.GNT_REF    = gnt_q[G_REF];
  assign bus.GNT_DMA    = gnt_q[G_DMA];
  assign bus.GNT_MEM    = gnt_q[G_MEM];
  assign bus.GNT_IO     = gnt_q[G_IO];
  assign bus.CGNTCACT_n = ~gnt_q[G_DMA];
  assign bus.CYCSTART   = cycstart_q;
  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.TMO        = tmo_q;
  assign bus.REFLATE    = reflate_q;

endmodule

// File: tb/tb_cyc_bus_arbiter.sv
// Directed and randomized checks of cyc_bus_arbiter against a cycle-level
// reference model built from the arbitration rules.
module tb_cyc_bus_arbiter;
  localparam int RECOV_CYC   = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int REF_LATE    = 16;

  logic sysclk = 1'b0;
  logic sys_rst_n;
  logic MR_n;

  cyc_bus_arbiter_if bus_if ();

  cyc_bus_arbiter #(
    .RECOV_CYC  (RECOV_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .REF_LATE   (REF_LATE)
  ) dut (
    .sysclk   (sysclk),
    .sys_rst_n(sys_rst_n),
    .MR_n     (MR_n),
    .bus      (bus_if.slave)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 active, 2 recovery; owner -1 = nobody.
  int m_phase, m_owner, m_pick, m_age, m_rec, m_refwait;
  bit m_pend, m_lastcpu, m_reflate, m_cs, m_tmo;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_pick = -1; m_age = 0; m_rec = 0;
    m_refwait = 0; m_pend = 0; m_lastcpu = 0; m_reflate = 0; m_cs = 0; m_tmo = 0;
  endtask

  function automatic int m_choose();
    int order[4];
    bit r[4];
    r = '{!bus_if.REFRQ_n, !bus_if.DMARQ_n, !bus_if.MREQ_n, !bus_if.IORQ_n};
    if (!bus_if.LOCK_n && m_lastcpu) order = '{0, 2, 3, 1};
    else                             order = '{0, 1, 2, 3};
    foreach (order[i]) if (r[order[i]]) return order[i];
    return -1;
  endfunction

  // Advance the model by one rising edge using the inputs present before it.
  task automatic model_edge();
    bit had_ref;
    had_ref = (m_owner == 0);
    if (!MR_n) begin
      model_reset();
      return;
    end
    if (had_ref) m_refwait = 0;
    else if (!bus_if.REFRQ_n && m_refwait < REF_LATE) m_refwait++;
    if (m_refwait == REF_LATE) m_reflate = 1;
    m_cs = 0;
    m_tmo = 0;
    if (m_phase == 0) begin
      if (m_pend) begin
        m_owner = m_pick; m_phase = 1; m_age = 0; m_cs = 1; m_pend = 0;
        if (m_pick == 1) m_lastcpu = 0;
        else if (m_pick >= 2) m_lastcpu = 1;
      end else begin
        m_pick = m_choose();
        m_pend = (m_pick >= 0);
      end
    end else if (m_phase == 1) begin
      if (bus_if.CYCEND || m_age == TIMEOUT_CYC - 1) begin
        m_tmo = !bus_if.CYCEND;
        m_owner = -1;
        m_rec = 0;
        m_phase = (RECOV_CYC == 0) ? 0 : 2;
      end else m_age++;
    end else begin
      if (m_rec == RECOV_CYC - 1) m_phase = 0;
      else m_rec++;
    end
  endtask

  function automatic logic [15:0] mdl_vec();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {7'd0, g[3], g[2], g[1], g[0], m_owner != 1, m_cs, m_phase != 0, m_tmo, m_reflate};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {7'd0, bus_if.GNT_IO, bus_if.GNT_MEM, bus_if.GNT_DMA, bus_if.GNT_REF,
            bus_if.CGNTCACT_n, bus_if.CYCSTART, bus_if.BUSY, bus_if.TMO, bus_if.REFLATE};
  endfunction

  task automatic step(input string tag);
    model_edge();
    @(posedge sysclk);
    #1;
    chk(tag, dut_vec(), mdl_vec());
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic end_cycle(input string tag);
    bus_if.CYCEND = 1'b1;
    step(tag);
    bus_if.CYCEND = 1'b0;
    run(3, tag);
  endtask

  int cs_cnt, gnt_cnt;
  logic [3:0] g_prev, g_now;

  initial begin
    sys_rst_n = 1'b0;
    MR_n = 1'b1;
    bus_if.REFRQ_n = 1'b1; bus_if.DMARQ_n = 1'b1; bus_if.MREQ_n = 1'b1;
    bus_if.IORQ_n = 1'b1;  bus_if.LOCK_n = 1'b1;  bus_if.CYCEND = 1'b0;
    model_reset();
    repeat (2) @(posedge sysclk);
    #1;
    chk("reset_state", dut_vec(), 16'h0010);
    sys_rst_n = 1'b1;

    // MEM beats IO, then IO after recovery
    bus_if.MREQ_n = 1'b0; bus_if.IORQ_n = 1'b0;
    step("t1_arb");
    step("t1_grant");
    chk("t1_mem_cycstart", {bus_if.GNT_MEM, bus_if.GNT_IO, bus_if.CYCSTART, bus_if.BUSY}, 4'b1011);
    bus_if.MREQ_n = 1'b1;
    run(3, "t1_hold");
    chk("t1_held", {bus_if.GNT_MEM, bus_if.CYCSTART}, 2'b10);
    bus_if.CYCEND = 1'b1;
    step("t1_end");
    bus_if.CYCEND = 1'b0;
    chk("t1_recov", {bus_if.GNT_MEM, bus_if.BUSY}, 2'b01);
    run(3, "t1_gap");
    step("t1_io");
    chk("t1_io_grant", {bus_if.GNT_IO, bus_if.CYCSTART}, 2'b11);
    bus_if.IORQ_n = 1'b1;
    end_cycle("t1_io_end");

    // lock ordering REF, MEM, DMA after a CPU cycle
    bus_if.REFRQ_n = 1'b0; bus_if.DMARQ_n = 1'b0; bus_if.MREQ_n = 1'b0; bus_if.LOCK_n = 1'b0;
    run(2, "t2_ref");
    chk("t2_ref_grant", {bus_if.GNT_REF, bus_if.GNT_DMA, bus_if.GNT_MEM}, 3'b100);
    bus_if.REFRQ_n = 1'b1;
    end_cycle("t2_ref_end");
    step("t2_mem");
    chk("t2_mem_grant", {bus_if.GNT_MEM, bus_if.GNT_DMA, bus_if.CGNTCACT_n}, 3'b101);
    bus_if.MREQ_n = 1'b1;
    end_cycle("t2_mem_end");
    step("t2_dma");
    chk("t2_dma_grant", {bus_if.GNT_DMA, bus_if.CGNTCACT_n}, 2'b10);
    bus_if.DMARQ_n = 1'b1; bus_if.LOCK_n = 1'b1;
    end_cycle("t2_dma_end");
    chk("t2_cgnt_idle", {15'd0, bus_if.CGNTCACT_n}, 16'd1);

    // DMA timeout
    bus_if.DMARQ_n = 1'b0;
    run(2, "t3_grant");
    chk("t3_cycstart", {bus_if.GNT_DMA, bus_if.CYCSTART}, 2'b11);
    bus_if.DMARQ_n = 1'b1;
    run(TIMEOUT_CYC - 1, "t3_wait");
    chk("t3_pre_tmo", {bus_if.TMO, bus_if.GNT_DMA}, 2'b01);
    step("t3_tmo");
    chk("t3_tmo_pulse", {bus_if.TMO, bus_if.GNT_DMA, bus_if.BUSY}, 3'b101);
    step("t3_after");
    chk("t3_tmo_once", {15'd0, bus_if.TMO}, 16'd0);
    run(2, "t3_recov");

    // refresh starved behind a long MEM cycle
    bus_if.MREQ_n = 1'b0;
    run(2, "t4_mem");
    bus_if.MREQ_n = 1'b1; bus_if.REFRQ_n = 1'b0;
    run(REF_LATE - 1, "t4_wait");
    chk("t4_not_late", {15'd0, bus_if.REFLATE}, 16'd0);
    step("t4_late");
    chk("t4_reflate_set", {15'd0, bus_if.REFLATE}, 16'd1);
    run(3, "t4_hold");
    end_cycle("t4_mem_end");
    step("t4_ref");
    chk("t4_ref_sticky", {bus_if.GNT_REF, bus_if.REFLATE}, 2'b11);
    bus_if.REFRQ_n = 1'b1;
    end_cycle("t4_ref_end");

    // master clear mid-cycle, then a stray CYCEND
    bus_if.MREQ_n = 1'b0;
    run(2, "t5_mem");
    MR_n = 1'b0;
    step("t5_mr");
    MR_n = 1'b1; bus_if.MREQ_n = 1'b1;
    chk("t5_cleared", dut_vec(), 16'h0010);
    bus_if.CYCEND = 1'b1;
    step("t5_late_end");
    bus_if.CYCEND = 1'b0;
    chk("t5_no_effect", dut_vec(), 16'h0010);

    // asynchronous reset mid-cycle
    bus_if.IORQ_n = 1'b0;
    run(2, "t7_io");
    bus_if.IORQ_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1 chk("t7_async_drop", dut_vec(), 16'h0010);
    model_reset();
    #1 sys_rst_n = 1'b1;
    step("t7_release");
    chk("t7_no_cycstart", {15'd0, bus_if.CYCSTART}, 16'd0);

    // randomized stress
    cs_cnt = 0; gnt_cnt = 0; g_prev = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      if (!bus_if.REFRQ_n) begin
        if (bus_if.GNT_REF) bus_if.REFRQ_n = 1'b1;
      end else bus_if.REFRQ_n = ($urandom_range(0, 19) != 0);
      bus_if.DMARQ_n = ($urandom_range(0, 2) != 0);
      bus_if.MREQ_n  = ($urandom_range(0, 2) != 0);
      bus_if.IORQ_n  = ($urandom_range(0, 2) != 0);
      bus_if.LOCK_n  = ($urandom_range(0, 1) != 0);
      bus_if.CYCEND  = ((c % 2000) < 1500) ? ($urandom_range(0, 7) == 0) : 1'b0;
      MR_n           = ($urandom_range(0, 499) != 0);
      step("t6_rand");
      g_now = {bus_if.GNT_IO, bus_if.GNT_MEM, bus_if.GNT_DMA, bus_if.GNT_REF};
      if (c % 50 == 0) chk("t6_onehot", {15'd0, $onehot0(g_now)}, 16'd1);
      if (bus_if.CYCSTART) cs_cnt++;
      if (g_now != 4'b0000 && g_prev == 4'b0000) gnt_cnt++;
      g_prev = g_now;
    end
    chk("t6_cycstart_per_grant", 16'(cs_cnt), 16'(gnt_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
